hazard_scoreboard_unit: RTL

//  Parametrised load-use hazard controller for the ID stage of the pipelined CPU.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/hazard_sb_entry.sv | 42 ++++
 rtl/hazard_scoreboard_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types for the ID-stage hazard logic.
//   REG_ADDR_W       : architectural register address width
//   REG_X0           : hard-wired zero register, never tracked
//   DEFAULT_LOAD_LAT : bubbles between a load and its consumer (classic load-use)
//   ctl_mode_e       : resolved pipeline-control mode for one cycle
package cpu_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int REG_X0           = 0;
  localparam int DEFAULT_LOAD_LAT = 1;

  typedef enum logic [1:0] {
    CTL_RUN    = 2'd0,
    CTL_FREEZE = 2'd1,
    CTL_FLUSH  = 2'd2,
    CTL_BUBBLE = 2'd3
  } ctl_mode_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown of cycles until a pending load result for
// this register becomes forwardable.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   hold  : pipeline frozen, counter keeps its value
//   set   : a load to this register was accepted, reload with LOAD_LAT
//   clear : a non-load producer to this register was accepted
//   busy  : counter nonzero, consumers must wait
module hazard_sb_entry
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 1,
  parameter int LOAD_LAT = DEFAULT_LOAD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic set,
  input  logic clear,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // Set has priority over the free-running decrement on the same entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!hold) begin
      if (set) begin
        cnt <= CNT_W'(LOAD_LAT);
      end else if (clear) begin
        cnt <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard controller for the ID stage using a per-register countdown
// scoreboard. Handles multi-cycle load latency, dcache-miss freeze, branch
// flush and counts hazard bubbles.
//   clk_i         : clock
//   rst_i         : synchronous active-low reset
//   rs_addr_ID_i  : ID source addresses, src k at [k*ADDR_W +: ADDR_W]
//   rs_valid_ID_i : src k is actually read
//   issue_valid_i : ID instruction requests to move to EX
//   issue_load_i  : issuing instruction is a load
//   issue_rd_i    : destination register of the issuing instruction
//   mem_stall_i   : dcache miss, whole pipeline frozen
//   flush_i       : branch taken, ID instruction discarded
//   NoOp_o        : inject bubble into ID/EX
//   Stall_o       : hold IF/ID
//   PCWrite_o     : PC update enable
//   stall_cnt_o   : saturating count of hazard-bubble cycles since reset
module hazard_scoreboard_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = DEFAULT_LOAD_LAT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*ADDR_W-1:0] rs_addr_ID_i,
  input  logic [NUM_SRC-1:0]        rs_valid_ID_i,
  input  logic                      issue_valid_i,
  input  logic                      issue_load_i,
  input  logic [ADDR_W-1:0]         issue_rd_i,
  input  logic                      mem_stall_i,
  input  logic                      flush_i,
  output logic                      NoOp_o,
  output logic                      Stall_o,
  output logic                      PCWrite_o,
  output logic [31:0]               stall_cnt_o
);

  localparam int NUM_REG = 1 << ADDR_W;
  // Keep at least one counter bit so a zero-latency build still elaborates.
  localparam int CNT_W   = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  logic [NUM_REG-1:0] busy;
  logic               hazard;
  logic               accept;
  ctl_mode_e          mode;
  logic [31:0]        stall_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // x0 is hard-wired, so it never owns a counter.
  assign busy[0] = 1'b0;

  generate
    for (genvar r = 1; r < NUM_REG; r++) begin : g_entry
      logic hit;
      assign hit = accept && (issue_rd_i == ADDR_W'(r));
      hazard_sb_entry #(
        .CNT_W    (CNT_W),
        .LOAD_LAT (LOAD_LAT)
      ) u_entry (
        .clk   (clk_i),
        .rst_n (rst_i),
        .hold  (mem_stall_i),
        .set   (hit && issue_load_i),
        .clear (hit && !issue_load_i),
        .busy  (busy[r])
      );
    end
  endgenerate

  always_comb begin
    logic [ADDR_W-1:0] src;
    hazard = 1'b0;
    src    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = rs_addr_ID_i[k*ADDR_W +: ADDR_W];
      if (rs_valid_ID_i[k] && (src != ADDR_W'(REG_X0)) && busy[src]) begin
        hazard = 1'b1;
      end
    end
  end

  assign accept = issue_valid_i && !mem_stall_i && !flush_i && !hazard;

  // Freeze outranks flush, which outranks the hazard bubble.
  always_comb begin
    if (mem_stall_i) begin
      mode = CTL_FREEZE;
    end else if (flush_i) begin
      mode = CTL_FLUSH;
    end else if (hazard) begin
      mode = CTL_BUBBLE;
    end else begin
      mode = CTL_RUN;
    end
  end

  always_comb begin
    Stall_o   = 1'b0;
    NoOp_o    = 1'b0;
    PCWrite_o = 1'b1;
    case (mode)
      CTL_FREEZE: begin
        Stall_o   = 1'b1;
        PCWrite_o = 1'b0;
      end
      CTL_BUBBLE: begin
        Stall_o   = 1'b1;
        NoOp_o    = 1'b1;
        PCWrite_o = 1'b0;
      end
      default: ;
    endcase
  end

  // NoOp_o is never raised while frozen, so the counter holds then as well.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (NoOp_o) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule
